// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states and
// the datapath mux codes the controller drives.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LI    = 6'b100111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_REXEC  = 4'd3,
        S_RWB    = 4'd4,
        S_IEXEC  = 4'd5,
        S_IWB    = 4'd6,
        S_MADDR  = 4'd7,
        S_MRD    = 4'd8,
        S_MWB    = 4'd9,
        S_MWR    = 4'd10,
        S_BEQ    = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the control FSM, slave the datapath.
interface multicycle_ctrl_if #(parameter int OPC_W = 6);

    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             pc_write;
    logic             pc_write_cond;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_source, pc_write, pc_write_cond
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_source, pc_write, pc_write_cond
    );

endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with wait-state memory handshake and retired-instruction count.
// Define ILLEGAL_TRAP_EN to trap (and latch illegal_op) on undefined opcodes instead of skipping them.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_ctrl_if.master bus,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             illegal_op
);

    state_t           cur, nxt;
    logic [OPC_W-1:0] opc_raw;
    logic [5:0]       op;
    logic             retire;

    assign opc_raw = bus.opcode;
    assign op      = 6'(opc_raw);
    assign state   = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_IDLE;
        else        cur <= nxt;
    end

    // Moore decode of the control word; only the fetch completion strobes follow mem_ready directly.
    always_comb begin
        nxt               = cur;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = ALUSRCB_B;
        bus.alu_op        = ALUOP_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        unique case (cur)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = ALUSRCB_FOUR;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    nxt          = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = ALUSRCB_IMM_SH2;
                case (op)
                    OP_RTYPE:       nxt = S_REXEC;
                    OP_LW, OP_SW:   nxt = S_MADDR;
                    OP_ADDI, OP_LI: nxt = S_IEXEC;
                    OP_BEQ:         nxt = S_BEQ;
                    OP_J:           nxt = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:        nxt = S_TRAP;
`else
                    default:        nxt = S_FETCH;
`endif
                endcase
            end
            S_REXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_FUNCT;
                nxt           = S_RWB;
            end
            S_RWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
                nxt           = S_FETCH;
            end
            S_IEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ALUSRCB_IMM;
                nxt           = S_IWB;
            end
            S_IWB: begin
                bus.reg_write = 1'b1;
                nxt           = S_FETCH;
            end
            S_MADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ALUSRCB_IMM;
                nxt           = (op == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) nxt = S_MWB;
            end
            S_MWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                nxt            = S_FETCH;
            end
            S_MWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready) nxt = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALUOP_SUB;
                bus.pc_source     = PCSRC_ALUOUT;
                bus.pc_write_cond = 1'b1;
                nxt               = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_source = PCSRC_JUMP;
                bus.pc_write  = 1'b1;
                nxt           = S_FETCH;
            end
            S_TRAP:  nxt = S_TRAP;
            default: nxt = S_IDLE;
        endcase
    end

    // An instruction retires only when a completion state hands back to fetch.
    assign retire = (nxt == S_FETCH) &&
                    (cur inside {S_RWB, S_IWB, S_MWB, S_MWR, S_BEQ, S_JUMP});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instr_cnt <= '0;
        else if (retire) instr_cnt <= instr_cnt + 1'b1;
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                illegal_op <= 1'b0;
        else if (cur == S_DECODE && nxt == S_TRAP) illegal_op <= 1'b1;
    end
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level step planner predicts the
// control word, state, retired count and trap flag for every cycle.
module tb_multicycle_ctrl;
    import mips_pkg::*;

    localparam int CNT_W = 4;

    localparam int K_FETCH = 0, K_DECODE = 1, K_REXEC = 2, K_RWB = 3, K_IEXEC = 4, K_IWB = 5;
    localparam int K_MADDR = 6, K_MRD = 7, K_MWB = 8, K_MWR = 9, K_BEQ = 10, K_JUMP = 11;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
    } ctrl_t;

    logic             clk;
    logic             rst_n;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;
    logic             illegal_op;

    multicycle_ctrl_if #(.OPC_W(6)) bus ();

    multicycle_ctrl #(.CNT_W(CNT_W), .OPC_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .state      (state),
        .instr_cnt  (instr_cnt),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int retired      = 0;
    int plan[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] opc, input logic z, input logic rdy);
        bus.opcode    = opc;
        bus.zero      = z;
        bus.mem_ready = rdy;
    endtask

    function automatic ctrl_t observed_ctrl();
        ctrl_t c;
        c = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
             bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
             bus.pc_write, bus.pc_write_cond};
        return c;
    endfunction

    // Control word each step must present, straight from the per-step table.
    function automatic ctrl_t exp_ctrl(input int k, input logic rdy);
        ctrl_t c;
        c = '0;
        case (k)
            K_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            K_DECODE: c.alu_src_b = 2'b11;
            K_REXEC:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            K_RWB:    begin c.reg_dst = 1; c.reg_write = 1; end
            K_IEXEC, K_MADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            K_IWB:    c.reg_write = 1;
            K_MRD:    begin c.mem_read = 1; c.i_or_d = 1; end
            K_MWB:    begin c.mem_to_reg = 1; c.reg_write = 1; end
            K_MWR:    begin c.mem_write = 1; c.i_or_d = 1; end
            K_BEQ:    begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_write_cond = 1; end
            K_JUMP:   begin c.pc_source = 2'b10; c.pc_write = 1; end
            default:  ;
        endcase
        return c;
    endfunction

    function automatic state_t exp_state(input int k);
        case (k)
            K_FETCH:  return S_FETCH;
            K_DECODE: return S_DECODE;
            K_REXEC:  return S_REXEC;
            K_RWB:    return S_RWB;
            K_IEXEC:  return S_IEXEC;
            K_IWB:    return S_IWB;
            K_MADDR:  return S_MADDR;
            K_MRD:    return S_MRD;
            K_MWB:    return S_MWB;
            K_MWR:    return S_MWR;
            K_BEQ:    return S_BEQ;
            default:  return S_JUMP;
        endcase
    endfunction

    task automatic build_plan(input logic [5:0] opc);
        plan.delete();
        plan.push_back(K_FETCH);
        plan.push_back(K_DECODE);
        case (opc)
            OP_RTYPE:       begin plan.push_back(K_REXEC); plan.push_back(K_RWB); end
            OP_ADDI, OP_LI: begin plan.push_back(K_IEXEC); plan.push_back(K_IWB); end
            OP_LW:          begin plan.push_back(K_MADDR); plan.push_back(K_MRD); plan.push_back(K_MWB); end
            OP_SW:          begin plan.push_back(K_MADDR); plan.push_back(K_MWR); end
            OP_BEQ:         plan.push_back(K_BEQ);
            OP_J:           plan.push_back(K_JUMP);
            default:        ;
        endcase
    endtask

    task automatic check_idle(input string tag);
        checkOutput({tag, " ctrl"}, 32'(observed_ctrl()), 32'd0);
        checkOutput({tag, " state"}, 32'(state), 32'(S_IDLE));
        checkOutput({tag, " cnt"}, 32'(instr_cnt), 32'd0);
        checkOutput({tag, " illegal"}, 32'(illegal_op), 32'd0);
    endtask

    // One clock of a planned step: drive, check before the edge, then advance.
    task automatic doStep(input int k, input logic [5:0] opc, input logic rdy);
        logic [5:0] drive_opc;
        ctrl_t      expect_c;
        drive_opc = (k == K_FETCH) ? 6'($urandom) : opc;
        applyStimulus(drive_opc, 1'($urandom_range(0, 1)), rdy);
        #1;
        expect_c = exp_ctrl(k, rdy);
        checkOutput($sformatf("ctrl k%0d", k), 32'(observed_ctrl()), 32'(expect_c));
        checkOutput($sformatf("state k%0d", k), 32'(state), 32'(exp_state(k)));
        checkOutput("cnt", 32'(instr_cnt), 32'(retired % (1 << CNT_W)));
        checkOutput("illegal", 32'(illegal_op), 32'd0);
        checkOutput("rd_wr_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic runInstr(input logic [5:0] opc, input int maxw);
        int   k;
        int   waits;
        logic rdy;
        build_plan(opc);
        foreach (plan[i]) begin
            k     = plan[i];
            waits = (k == K_FETCH || k == K_MRD || k == K_MWR) ? $urandom_range(0, maxw) : 0;
            for (int w = 0; w <= waits; w++) begin
                if (k == K_FETCH || k == K_MRD || k == K_MWR) rdy = (w == waits);
                else rdy = 1'($urandom_range(0, 1));
                doStep(k, opc, rdy);
            end
        end
        if (plan.size() > 2) retired = retired + 1;
    endtask

    logic [5:0] opc_tbl [8];
    logic [5:0] bad_tbl [3];
    logic [5:0] pick;

    initial begin
        opc_tbl = '{OP_RTYPE, OP_ADDI, OP_LI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_RTYPE};
        bad_tbl = '{6'h3F, 6'h01, 6'h11};
        rst_n = 1'b0;
        applyStimulus(6'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        check_idle("idle");
        @(posedge clk);
        #1;

        // Directed openers: R-type with memory ready, lw with a long read wait, beq, j then sw.
        runInstr(OP_RTYPE, 0);
        build_plan(OP_LW);
        doStep(K_FETCH, OP_LW, 1'b1);
        doStep(K_DECODE, OP_LW, 1'b1);
        doStep(K_MADDR, OP_LW, 1'b1);
        repeat (3) doStep(K_MRD, OP_LW, 1'b0);
        doStep(K_MRD, OP_LW, 1'b1);
        doStep(K_MWB, OP_LW, 1'b0);
        retired = retired + 1;
        runInstr(OP_BEQ, 0);
        runInstr(OP_BEQ, 2);
        runInstr(OP_J, 1);
        runInstr(OP_SW, 3);

        // Random stream long enough to wrap the 4-bit counter several times.
        for (int n = 0; n < 70; n++) begin
            pick = opc_tbl[$urandom_range(0, 7)];
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) pick = bad_tbl[$urandom_range(0, 2)];
`endif
            runInstr(pick, 3);
        end

        // Reset asserted while the load is stalled on memory.
        doStep(K_FETCH, OP_LW, 1'b1);
        doStep(K_DECODE, OP_LW, 1'b1);
        doStep(K_MADDR, OP_LW, 1'b1);
        doStep(K_MRD, OP_LW, 1'b0);
        applyStimulus(OP_LW, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        retired = 0;
        @(posedge clk);
        #1;
        check_idle("rst_hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 18; n++) runInstr(opc_tbl[$urandom_range(0, 7)], 1);

        // Undefined opcode at the end since the trap build never leaves the trap.
        doStep(K_FETCH, 6'h3F, 1'b1);
        doStep(K_DECODE, 6'h3F, 1'b1);
`ifdef ILLEGAL_TRAP_EN
        for (int n = 0; n < 4; n++) begin
            applyStimulus(OP_RTYPE, 1'b1, 1'($urandom_range(0, 1)));
            #1;
            checkOutput("trap state", 32'(state), 32'(S_TRAP));
            checkOutput("trap ctrl", 32'(observed_ctrl()), 32'd0);
            checkOutput("trap illegal", 32'(illegal_op), 32'd1);
            checkOutput("trap cnt", 32'(instr_cnt), 32'(retired % (1 << CNT_W)));
            @(posedge clk);
            #1;
        end
`else
        runInstr(OP_ADDI, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
